// File: rtl/uart_tx_scheduler.sv
// Two-requester round-robin scheduler feeding a UART byte transmitter.
// Arbitration is per message; bytes of one message go back-to-back.
module uart_tx_scheduler #(
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic       hwclk,
  input  logic       rst,
  input  logic       a_req,
  input  logic [7:0] a_data,
  input  logic       a_last,
  output logic       a_ack,
  input  logic       b_req,
  input  logic [7:0] b_data,
  input  logic       b_last,
  output logic       b_ack,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic [1:0] owner,
  output logic       err
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] WAIT_BUSY = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] GAP       = 3'd4;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  logic [2:0]    state;
  logic [1:0]    own;
  logic          ptr;
  logic          last_q;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;

  logic gnt_b;
  logic sel_b;
  logic sel_req;
  logic own_req;
  logic load;
  logic go;
  logic tmo;
  logic msg_end;

  assign own_req = (own[0] & a_req) | (own[1] & b_req);
  // ptr=1 gives B priority when both request
  assign gnt_b   = b_req & (~a_req | ptr);
  assign sel_b   = (state == IDLE) ? gnt_b : own[1];
  assign sel_req = sel_b ? b_req : a_req;

  assign load = ((state == IDLE) & (a_req | b_req))
              | ((state == WAIT_DONE) & ~tx_busy & ~last_q);

  assign go  = (state == START) & own_req;
  assign tmo = (state == WAIT_BUSY) & ~tx_busy
             & (tcnt == TW'(TIMEOUT - 1));

  assign msg_end = ((state == START) & ~own_req)
                 | tmo
                 | ((state == WAIT_DONE) & ~tx_busy & last_q);

  assign tx_start = go & ~rst;
  assign a_ack    = go & own[0] & ~rst;
  assign b_ack    = go & own[1] & ~rst;
  assign err      = tmo & ~rst;
  assign owner    = own;

  always_ff @(posedge hwclk) begin
    if (rst) begin
      state   <= IDLE;
      own     <= 2'b00;
      ptr     <= 1'b0;
      last_q  <= 1'b0;
      tcnt    <= '0;
      gcnt    <= '0;
      tx_data <= 8'h00;
    end else begin
      if (load & sel_req) begin
        tx_data <= sel_b ? b_data : a_data;
        last_q  <= sel_b ? b_last : a_last;
      end
      if (msg_end) begin
        state <= GAP;
        own   <= 2'b00;
        ptr   <= own[0];
        gcnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (a_req | b_req) begin
              state <= START;
              own   <= gnt_b ? 2'b10 : 2'b01;
            end
          end
          START: begin
            state <= WAIT_BUSY;
            tcnt  <= '0;
          end
          WAIT_BUSY: begin
            if (tx_busy) state <= WAIT_DONE;
            else tcnt <= tcnt + TW'(1);
          end
          WAIT_DONE: begin
            if (!tx_busy) state <= START;
          end
          GAP: begin
            if (gcnt == GW'(GAP_CYCLES - 1)) state <= IDLE;
            else gcnt <= gcnt + GW'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: requester/transmitter models
// plus an in-order scoreboard of tx bytes and timeout errors.
module tb_uart_tx_scheduler;

  localparam int GAP  = 4;
  localparam int TMO  = 8;
  localparam int BLEN = 10;

  logic       hwclk = 1'b0;
  logic       rst;
  logic       a_req, a_last, a_ack;
  logic [7:0] a_data;
  logic       b_req, b_last, b_ack;
  logic [7:0] b_data;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [1:0] owner;
  logic       err;

  uart_tx_scheduler #(.GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .hwclk(hwclk), .rst(rst),
    .a_req(a_req), .a_data(a_data), .a_last(a_last), .a_ack(a_ack),
    .b_req(b_req), .b_data(b_data), .b_last(b_last), .b_ack(b_ack),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .owner(owner), .err(err)
  );

  always #5 hwclk = ~hwclk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge hwclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // transmitter model: busy for BLEN cycles after each load
  bit model_en = 1'b1;
  int bcnt = 0;
  always @(posedge hwclk) begin
    if (rst) begin
      tx_busy <= 1'b0;
      bcnt    <= 0;
    end else if (tx_start && model_en) begin
      tx_busy <= 1'b1;
      bcnt    <= BLEN;
    end else if (tx_busy) begin
      if (bcnt == 1) tx_busy <= 1'b0;
      bcnt <= bcnt - 1;
    end
  end

  // requester models: queue of {last, data}
  logic [8:0] aq[$];
  logic [8:0] bq[$];
  bit a_drop = 1'b0;

  function automatic void drive_a();
    a_req  = aq.size() > 0;
    a_data = 8'h00;
    a_last = 1'b0;
    if (aq.size() > 0) begin
      a_data = aq[0][7:0];
      a_last = aq[0][8];
    end
  endfunction

  function automatic void drive_b();
    b_req  = bq.size() > 0;
    b_data = 8'h00;
    b_last = 1'b0;
    if (bq.size() > 0) begin
      b_data = bq[0][7:0];
      b_last = bq[0][8];
    end
  endfunction

  initial forever begin
    @(negedge hwclk);
    if (a_ack) begin
      @(posedge hwclk);
      #1;
      if (aq.size() > 0) void'(aq.pop_front());
      if (a_drop) begin
        aq.delete();
        a_drop = 1'b0;
      end
      drive_a();
    end
  end

  initial forever begin
    @(negedge hwclk);
    if (b_ack) begin
      @(posedge hwclk);
      #1;
      if (bq.size() > 0) void'(bq.pop_front());
      drive_b();
    end
  end

  // scoreboard
  typedef struct packed {
    logic       is_err;
    logic [1:0] own;
    logic [7:0] d;
  } exp_t;
  exp_t expq[$];

  function automatic void exp_tx(input logic [1:0] o, input logic [7:0] d);
    expq.push_back('{is_err: 1'b0, own: o, d: d});
  endfunction

  function automatic void exp_err();
    expq.push_back('{is_err: 1'b1, own: 2'b00, d: 8'h00});
  endfunction

  int n_start = 0;
  int n_err = 0;
  int n_aack = 0;
  int start_cyc = 0;
  int err_cyc = 0;

  always @(negedge hwclk) begin
    exp_t e;
    if (tx_start || a_ack || b_ack) begin
      chk("ack_exclusive", {31'd0, a_ack & b_ack}, 0);
      chk("start_while_busy", {31'd0, tx_start & tx_busy}, 0);
    end
    if (a_ack) begin
      n_aack++;
      chk("a_ack_owner", {30'd0, owner}, 1);
    end
    if (b_ack) chk("b_ack_owner", {30'd0, owner}, 2);
    if (tx_start) begin
      n_start++;
      start_cyc = cyc;
      if (expq.size() == 0) begin
        chk("unexpected_tx_start", {24'd0, tx_data}, 32'hffff_ffff);
      end else begin
        e = expq.pop_front();
        chk("tx_kind", {31'd0, e.is_err}, 0);
        chk("tx_data", {24'd0, tx_data}, {24'd0, e.d});
        chk("tx_owner", {30'd0, owner}, {30'd0, e.own});
      end
    end
    if (err) begin
      n_err++;
      err_cyc = cyc;
      if (expq.size() == 0) begin
        chk("unexpected_err", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("err_kind", {31'd0, e.is_err}, 1);
      end
    end
  end

  task automatic tick();
    @(posedge hwclk);
    #1;
  endtask

  task automatic wait_starts(input int n);
    int k = 0;
    while (n_start < n && k < 400) begin
      tick();
      k++;
    end
    chk("wait_tx_start", {31'd0, n_start >= n}, 1);
  endtask

  task automatic drain();
    int k = 0;
    while ((expq.size() != 0 || owner != 2'b00) && k < 800) begin
      tick();
      k++;
    end
    chk("drain", expq.size(), 0);
    repeat (GAP + 2) tick();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tx_data"}, {24'd0, tx_data}, 0);
    chk({tag, "_owner"}, {30'd0, owner}, 0);
    chk({tag, "_tx_start"}, {31'd0, tx_start}, 0);
    chk({tag, "_a_ack"}, {31'd0, a_ack}, 0);
    chk({tag, "_b_ack"}, {31'd0, b_ack}, 0);
    chk({tag, "_err"}, {31'd0, err}, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int req_cyc, s1, g0, n0, a0, e0;
    rst = 1'b1;
    drive_a();
    drive_b();
    repeat (3) tick();
    chk_reset("rst_held");
    rst = 1'b0;
    tick();
    chk_reset("after_rst");

    // three-byte message from A
    req_cyc = cyc;
    n0 = n_start;
    aq.push_back({1'b0, 8'h48});
    aq.push_back({1'b0, 8'h69});
    aq.push_back({1'b1, 8'h0A});
    exp_tx(2'b01, 8'h48);
    exp_tx(2'b01, 8'h69);
    exp_tx(2'b01, 8'h0A);
    drive_a();
    wait_starts(n0 + 1);
    chk("first_start_latency", start_cyc - req_cyc, 1);
    s1 = start_cyc;
    wait_starts(n0 + 2);
    chk("byte_to_byte", start_cyc - s1, BLEN + 2);
    wait_starts(n0 + 3);
    begin
      int k = 0;
      while (owner != 2'b00 && k < 100) begin
        tick();
        k++;
      end
    end
    g0 = cyc;
    // B raised during the gap must wait it out
    bq.push_back({1'b1, 8'hC3});
    exp_tx(2'b10, 8'hC3);
    drive_b();
    for (int i = 0; i < GAP; i++) begin
      chk("gap_owner", {30'd0, owner}, 0);
      chk("gap_no_start", {31'd0, tx_start}, 0);
      tick();
    end
    wait_starts(n0 + 4);
    chk("gap_then_grant", start_cyc - g0, GAP + 1);
    chk("a_ack_count", n_aack, 3);
    drain();

    // round robin from reset
    do_reset();
    aq.push_back({1'b1, 8'h11});
    bq.push_back({1'b1, 8'h22});
    exp_tx(2'b01, 8'h11);
    exp_tx(2'b10, 8'h22);
    drive_a();
    drive_b();
    drain();
    aq.push_back({1'b1, 8'h33});
    bq.push_back({1'b1, 8'h44});
    exp_tx(2'b01, 8'h33);
    exp_tx(2'b10, 8'h44);
    drive_a();
    drive_b();
    drain();
    aq.push_back({1'b1, 8'h55});
    exp_tx(2'b01, 8'h55);
    drive_a();
    drain();
    aq.push_back({1'b1, 8'h66});
    bq.push_back({1'b1, 8'h77});
    exp_tx(2'b10, 8'h77);
    exp_tx(2'b01, 8'h66);
    drive_a();
    drive_b();
    drain();

    // timeout: transmitter never goes busy
    model_en = 1'b0;
    n0 = n_start;
    e0 = n_err;
    aq.push_back({1'b1, 8'h5A});
    exp_tx(2'b01, 8'h5A);
    exp_err();
    drive_a();
    wait_starts(n0 + 1);
    s1 = start_cyc;
    bq.push_back({1'b1, 8'h5B});
    exp_tx(2'b10, 8'h5B);
    drive_b();
    begin
      int k = 0;
      while (n_err == e0 && k < 100) begin
        tick();
        k++;
      end
    end
    chk("err_seen", n_err - e0, 1);
    chk("err_latency", err_cyc - s1, TMO);
    chk("err_owner_after", {30'd0, owner}, 0);
    model_en = 1'b1;
    wait_starts(n0 + 2);
    chk("start_after_err_gap", start_cyc - err_cyc, GAP + 2);
    drain();

    // A drops after first byte, B pending
    a0 = n_aack;
    a_drop = 1'b1;
    aq.push_back({1'b0, 8'h01});
    aq.push_back({1'b0, 8'h02});
    aq.push_back({1'b1, 8'h03});
    bq.push_back({1'b1, 8'hBB});
    exp_tx(2'b01, 8'h01);
    exp_tx(2'b10, 8'hBB);
    drive_a();
    drive_b();
    drain();
    chk("drop_a_acks", n_aack - a0, 1);

    // reset in WAIT_DONE of B's second byte
    n0 = n_start;
    bq.push_back({1'b0, 8'hB1});
    bq.push_back({1'b0, 8'hB2});
    bq.push_back({1'b1, 8'hB3});
    exp_tx(2'b10, 8'hB1);
    exp_tx(2'b10, 8'hB2);
    drive_b();
    wait_starts(n0 + 2);
    repeat (4) tick();
    aq.push_back({1'b1, 8'hA1});
    drive_a();
    rst = 1'b1;
    @(negedge hwclk);
    chk("rst_cycle_start", {31'd0, tx_start}, 0);
    chk("rst_cycle_acks", {30'd0, a_ack, b_ack}, 0);
    tick();
    rst = 1'b0;
    chk_reset("mid_msg_rst");
    exp_tx(2'b01, 8'hA1);
    exp_tx(2'b10, 8'hB3);
    @(negedge hwclk);
    chk("post_rst_start", {31'd0, tx_start}, 0);
    chk("post_rst_acks", {30'd0, a_ack, b_ack}, 0);
    drain();

    chk("queue_empty", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter GAP_CYCLES, default 16, idle cycles inserted after every message before the next grant (min 1).
REQ-002 Parameter TIMEOUT, default 64, max cycles from tx_start to tx_busy rising before the byte is aborted (min 2).
REQ-003 hwclk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 a_req  input  1  requester A holds a byte on a_data; held high for the whole message.
REQ-006 a_data  input  8  requester A byte; stable while a_req=1 and a_ack=0.
REQ-007 a_last  input  1  current a_data byte is the last of A's message.
REQ-008 a_ack  output  1  one-cycle pulse: A's current byte taken; A presents the next byte from the following cycle.
REQ-009 b_req, b_data[7:0], b_last, b_ack  same directions, widths and meaning as A, for requester B.
REQ-010 tx_data  output  8  byte to UART shift transmitter; held until the next load.
REQ-011 tx_start  output  1  one-cycle load strobe to transmitter.
REQ-012 tx_busy  input  1  transmitter is shifting a frame.
REQ-013 owner  output  2  00 none, 01 A, 10 B; current message owner.
REQ-014 err  output  1  one-cycle pulse on timeout abort.

Function
REQ-015 State machine SHALL have exactly states IDLE, START, WAIT_BUSY, WAIT_DONE, GAP.
REQ-016 IDLE: if neither req high, stay, owner=00; else grant one requester, set owner, go START next cycle.
REQ-017 Arbitration SHALL be round-robin at message granularity: priority pointer resets to A; when both req high, pointer's requester wins; pointer moves to the non-winner when the message ends (normal, dropped or aborted).
REQ-018 Only one request high: that requester wins regardless of pointer; pointer still updated per REQ-017.
REQ-019 START (1 cycle): tx_data <= owner's data, tx_start=1, owner's ack=1, owner's last flag captured; go WAIT_BUSY.
REQ-020 Owner's req low on entering START (drop mid-message): no tx_start, no ack; go GAP.
REQ-021 WAIT_BUSY: tx_busy=1 -> WAIT_DONE; tx_busy 0 for TIMEOUT consecutive cycles after tx_start -> err pulse, go GAP.
REQ-022 Timeout counter cleared on every START; width ceil(log2(TIMEOUT+1)).
REQ-023 WAIT_DONE: on tx_busy=0, captured last=1 -> GAP; last=0 -> START (next byte of same owner, no re-arbitration).
REQ-024 GAP: owner=00, count GAP_CYCLES cycles, then IDLE; requests during GAP ignored.
REQ-025 Non-owner SHALL never see ack; a_ack and b_ack never high together.
REQ-026 tx_start SHALL never assert while tx_busy=1 or within GAP.
REQ-027 Byte-to-byte latency within a message: tx_start exactly 1 cycle after tx_busy falls sampled in WAIT_DONE.
REQ-028 IDLE with req high to first tx_start: 2 cycles (grant cycle + START).

Reset
REQ-029 rst=1 at any edge, any state: next state IDLE; tx_data=8'h00, tx_start=0, a_ack=0, b_ack=0, owner=00, err=0, pointer=A, counters=0.
REQ-030 Reset mid-message SHALL abandon the message; no ack or tx_start in the reset cycle or the cycle after.

Verification
REQ-031 A sends 3 bytes 0x48,0x69,0x0A (last on 3rd), model busy 10 cycles each -> three tx_start pulses with those tx_data, three a_ack, owner=01 throughout, then GAP_CYCLES of owner=00.
REQ-032 a_req and b_req high together after reset, 1-byte messages each -> A granted first, then B; repeat with both high -> A again (pointer alternates).
REQ-033 tx_busy held 0 after tx_start -> err pulse exactly TIMEOUT cycles after tx_start, owner=00, no further tx_start until GAP done.
REQ-034 a_req dropped after 1st byte of 3-byte message -> no 2nd tx_start, FSM to GAP, B (pending) granted after GAP.
REQ-035 rst asserted during WAIT_DONE of 2nd byte -> next cycle all outputs at reset values; after release, pending request re-arbitrated from A-priority.
REQ-036 Throughout all scenarios assert: a_ack&b_ack never 1; tx_start never 1 while tx_busy=1.
